// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared widths, source encodings and write-request type for the regfile write-side controller.
// Used by the controller, its arbiter and the handshake interface.
package regfile_wb_ctrl_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  // Encoding of the last-granted completion source held by the arbiter
  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_LSU = 1'b1;

  typedef logic [AW-1:0]   raddr_t;
  typedef logic [XLEN-1:0] xdata_t;

  typedef struct packed {
    raddr_t rd;
    xdata_t data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_ctrl_if.sv
// Issue, hazard-check, completion and regfile-write signals of the write-side controller.
// The slave modport is the controller; the master modport is decode/execute/regfile.
interface regfile_wb_ctrl_if;
  import regfile_wb_ctrl_pkg::*;

  logic   issue_valid;
  raddr_t issue_rd;
  logic   issue_ready;
  raddr_t chk_rs1;
  raddr_t chk_rs2;
  logic   rs1_busy;
  logic   rs2_busy;
  logic   alu_valid;
  raddr_t alu_rd;
  xdata_t alu_data;
  logic   alu_ready;
  logic   lsu_valid;
  raddr_t lsu_rd;
  xdata_t lsu_data;
  logic   lsu_ready;
  logic   rf_wen;
  raddr_t rf_waddr;
  xdata_t rf_wdata;
  logic   err_spurious;

  modport slave (
    input  issue_valid, issue_rd, chk_rs1, chk_rs2,
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    output issue_ready, rs1_busy, rs2_busy, alu_ready, lsu_ready,
    output rf_wen, rf_waddr, rf_wdata, err_spurious
  );

  modport master (
    output issue_valid, issue_rd, chk_rs1, chk_rs2,
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    input  issue_ready, rs1_busy, rs2_busy, alu_ready, lsu_ready,
    input  rf_wen, rf_waddr, rf_wdata, err_spurious
  );

endinterface

// File: rtl/regfile_wb_ctrl_wb_rr_arb2.sv
// Two-way round-robin arbiter (ALU/LSU), combinational grant, registered last-grant pointer.
// Grant depends on valid only; the loser simply keeps its valid asserted.
module wb_rr_arb2
  import regfile_wb_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic alu_vld_i,
  input  logic lsu_vld_i,
  output logic gnt_alu_o,
  output logic gnt_lsu_o
);

  logic rr_last_q, rr_last_d;

  always_comb begin
    gnt_alu_o = alu_vld_i & (~lsu_vld_i | (rr_last_q == SRC_LSU));
    gnt_lsu_o = lsu_vld_i & (~alu_vld_i | (rr_last_q == SRC_ALU));
    rr_last_d = rr_last_q;
    if (gnt_alu_o) begin
      rr_last_d = SRC_ALU;
    end else if (gnt_lsu_o) begin
      rr_last_d = SRC_LSU;
    end
  end

  // LSU counts as last granted out of reset so the ALU wins the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last_q <= SRC_LSU;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Regfile write-side controller: pending-write scoreboard, ALU/LSU round-robin, registered write stage (1 cycle).
// Issue stalls while its rd is busy; one completion accepted per cycle, the other source holds.
module regfile_wb_ctrl
  import regfile_wb_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  regfile_wb_ctrl_if.slave  bus
);

  logic [NREG-1:0] busy_q, busy_d;
  logic            rf_wen_q, rf_wen_d;
  raddr_t          rf_waddr_q, rf_waddr_d;
  xdata_t          rf_wdata_q, rf_wdata_d;
  logic            err_q, err_d;

  logic            gnt_alu, gnt_lsu, grant;
  logic            issue_fire;
  logic            wr_vld;
  wb_req_t         sel_req;

  wb_rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .alu_vld_i (bus.alu_valid),
    .lsu_vld_i (bus.lsu_valid),
    .gnt_alu_o (gnt_alu),
    .gnt_lsu_o (gnt_lsu)
  );

  assign grant         = gnt_alu | gnt_lsu;
  assign bus.alu_ready = gnt_alu;
  assign bus.lsu_ready = gnt_lsu;

  assign bus.issue_ready = ~busy_q[bus.issue_rd];
  assign bus.rs1_busy    = busy_q[bus.chk_rs1];
  assign bus.rs2_busy    = busy_q[bus.chk_rs2];
  assign issue_fire      = bus.issue_valid & bus.issue_ready;

  always_comb begin
    sel_req = gnt_lsu ? '{rd: bus.lsu_rd, data: bus.lsu_data}
                      : '{rd: bus.alu_rd, data: bus.alu_data};
  end

  // Completions to x0 are consumed but never reach the regfile
  assign wr_vld = grant & (sel_req.rd != '0);

  always_comb begin
    busy_d     = busy_q;
    rf_wen_d   = wr_vld;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    err_d      = err_q;

    if (wr_vld) begin
      rf_waddr_d = sel_req.rd;
      rf_wdata_d = sel_req.data;
      if (!busy_q[sel_req.rd]) begin
        err_d = 1'b1;
      end
    end

    // Clear first so a same-cycle issue to the same register leaves it busy
    if (rf_wen_q) begin
      busy_d[rf_waddr_q] = 1'b0;
    end
    if (issue_fire && (bus.issue_rd != '0)) begin
      busy_d[bus.issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= '0;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      err_q      <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      err_q      <= err_d;
    end
  end

  assign bus.rf_wen       = rf_wen_q;
  assign bus.rf_waddr     = rf_waddr_q;
  assign bus.rf_wdata     = rf_wdata_q;
  assign bus.err_spurious = err_q;

endmodule

// File: doc/regfile_wb_ctrl.md
Name: regfile_wb_ctrl

Overview:
- Write-side controller for the 32x32 register file; it is the producer of the regfile's wen/waddr/wdata port.
- Tracks pending destination registers (scoreboard), set at issue and cleared at writeback.
- Arbitrates two completion sources (ALU, LSU) onto the single write port, round-robin, with a registered write stage.
- Reports per-source-register busy status so decode can stall on RAW/WAW hazards.

Parameters:
- XLEN, 32, data width of write data.
- NREG, 32, number of architectural registers; x0 is hardwired zero.
- AW, 5, register address width, equal to log2(NREG).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- issue_valid  in  1  decode issues an instruction that writes issue_rd.
- issue_rd  in  AW  destination register of the issued instruction.
- issue_ready  out  1  issue accepted this cycle.
- chk_rs1  in  AW  source register 1 to check.
- chk_rs2  in  AW  source register 2 to check.
- rs1_busy  out  1  chk_rs1 has a pending write.
- rs2_busy  out  1  chk_rs2 has a pending write.
- alu_valid  in  1  ALU result available.
- alu_rd  in  AW  ALU destination register.
- alu_data  in  XLEN  ALU result.
- alu_ready  out  1  ALU result accepted.
- lsu_valid  in  1  LSU load result available.
- lsu_rd  in  AW  LSU destination register.
- lsu_data  in  XLEN  LSU result.
- lsu_ready  out  1  LSU result accepted.
- rf_wen  out  1  regfile write enable (registered).
- rf_waddr  out  AW  regfile write address (registered).
- rf_wdata  out  XLEN  regfile write data (registered).
- err_spurious  out  1  sticky flag: a completion targeted a non-busy nonzero register.

Behaviour:
- Reset: busy[31:1]=0, rf_wen=0, rf_waddr=0, rf_wdata=0, err_spurious=0, rr_last=1 (LSU was last granted, so ALU wins the first tie). Reset mid-operation discards any pending write stage and clears the whole scoreboard.
- Scoreboard:
  - busy[0] is constantly 0.
  - rsN_busy = busy[chk_rsN], combinational.
  - issue_ready = !busy[issue_rd]; this stalls WAW hazards.
  - Issue handshake (issue_valid & issue_ready) with issue_rd != 0 sets busy[issue_rd] at the next edge.
  - Issue with rd = 0 is accepted and has no effect.
- Arbitration, combinational, one grant per cycle:
  - Only ALU valid: grant ALU. Only LSU valid: grant LSU.
  - Both valid: grant the source other than rr_last.
  - alu_ready = grant_alu, lsu_ready = grant_lsu. Ready depends on valid; sources must not wait for ready before asserting valid.
  - rr_last updates to the granted source on every grant.
- Write stage:
  - A handshake in cycle N yields rf_wen=1, rf_waddr=rd, rf_wdata=data in cycle N+1.
  - No grant in cycle N yields rf_wen=0 in N+1; rf_waddr and rf_wdata hold their values.
  - rd = 0: the completion is accepted and rf_wen stays 0 in N+1.
- Busy clear:
  - busy[rf_waddr] clears at the end of the cycle in which rf_wen=1, the same edge the regfile captures the data.
  - Hence rs_busy falls at N+2, when the regfile read already returns the new value. There is no forwarding path.
- Simultaneous set and clear of the same register in one cycle: set wins, and the register stays busy.
- Spurious completion: a handshake with rd != 0 and busy[rd]=0 still writes, and sets err_spurious. err_spurious clears only on rst.
- Throughput: one write per cycle sustained. The non-granted source waits with its valid held and data stable.

Decomposition:
- Shared package holds XLEN, AW, NREG and the source encoding constants (SRC_ALU=0, SRC_LSU=1) used for rr_last.
- Natural sub-module: wb_rr_arb2, the 2-way round-robin arbiter with valid inputs, grant outputs and the last-grant register.
- The scoreboard and write-stage registers stay in the top module.

Test Plan:
- Reset then idle: all outputs 0, issue_ready=1; chk_rs1=5 gives rs1_busy=0.
- Issue rd=5 in cycle 0; busy from cycle 1. ALU completes rd=5, data 0xDEADBEEF, in cycle 3: rf_wen=1, waddr=5, wdata=0xDEADBEEF in cycle 4; rs1_busy(5)=0 from cycle 5.
- Issue rd=3 and rd=7; ALU(rd=3) and LSU(rd=7) valid together for 2 cycles: ALU granted first, LSU second; writes at consecutive cycles, waddr 3 then 7.
- WAW and issue-during-clear:
  - With rd=9 busy, issue rd=9 sees issue_ready=0.
  - In the cycle rf_wen=1, waddr=9, issue rd=9 is still rejected (not ready). In the next cycle it is accepted and busy stays set.
- rd=0 handling: issue rd=0 leaves no busy bit set; ALU completion to rd=0 gives alu_ready=1, rf_wen stays 0, and err_spurious stays 0.
- Spurious and reset:
  - LSU completes rd=12 while not busy: write occurs and err_spurious=1 and stays 1.
  - Assert rst while a write is pending: next cycle rf_wen=0, all busy bits 0, err_spurious=0.
